// File: rtl/wbi_burst_sched.sv
// Round-robin command scheduler with burst-locked grants for one staging command port.
// An idle-stall watchdog releases a grant whose requester stops delivering beats.
module wbi_burst_sched #(
  parameter  int NR  = 4,
  parameter  int BL  = 10,
  parameter  int TOW = 8,
  localparam int IW  = (NR > 1) ? $clog2(NR) : 1
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic [NR-1:0]    req_wval_i,
  input  logic [NR-1:0]    req_we_i,
  input  logic [NR*BL-1:0] req_bl_i,
  input  logic             stg_wrdy_i,
  output logic             stg_wval_o,
  output logic [NR-1:0]    req_wrdy_o,
  output logic [IW-1:0]    gnt_idx_o,
  output logic             gnt_vld_o,
  output logic [BL-1:0]    beat_cnt_o,
  output logic             tout_o
);

  typedef enum logic {S_IDLE, S_LOCK} state_t;

  // The watchdog fires on the idle cycle that would take the counter to 2^TOW-1.
  localparam logic [TOW-1:0] WD_LAST = {{(TOW-1){1'b1}}, 1'b0};

  state_t          r_state;
  logic [IW-1:0]   r_gnt_idx;
  logic            r_gnt_vld;
  logic [BL-1:0]   r_beat_cnt;
  logic            r_tout;
  logic [IW-1:0]   r_rr_ptr;
  logic [TOW-1:0]  r_wdog;

  logic            w_any;
  logic [IW-1:0]   w_pick;
  logic [BL-1:0]   w_pick_bl;
  logic [BL-1:0]   w_load_cnt;
  logic [IW-1:0]   w_next_ptr;
  logic            w_accept;

  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    // Walk downward so the smallest offset from the pointer is the last one written.
    for (int i = NR - 1; i >= 0; i--) begin
      int k;
      k = int'(r_rr_ptr) + i;
      if (k >= NR) k = k - NR;
      if (req_wval_i[k]) begin
        w_any  = 1'b1;
        w_pick = IW'(k);
      end
    end
  end

  assign w_pick_bl  = req_bl_i[int'(w_pick)*BL +: BL];
  assign w_load_cnt = (req_we_i[w_pick] && (w_pick_bl != '0)) ? w_pick_bl : BL'(1);
  assign w_next_ptr = (r_gnt_idx == IW'(NR - 1)) ? '0 : r_gnt_idx + 1'b1;
  assign w_accept   = stg_wval_o & stg_wrdy_i;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_gnt_idx  <= '0;
      r_gnt_vld  <= 1'b0;
      r_beat_cnt <= '0;
      r_tout     <= 1'b0;
      r_rr_ptr   <= '0;
      r_wdog     <= '0;
    end else begin
      r_tout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt_idx  <= w_pick;
            r_gnt_vld  <= 1'b1;
            r_beat_cnt <= w_load_cnt;
            r_wdog     <= '0;
            r_state    <= S_LOCK;
          end
        end
        S_LOCK: begin
          if (w_accept) begin
            r_wdog     <= '0;
            r_beat_cnt <= r_beat_cnt - 1'b1;
            if (r_beat_cnt == BL'(1)) begin
              r_gnt_vld <= 1'b0;
              r_rr_ptr  <= w_next_ptr;
              r_state   <= S_IDLE;
            end
          end else if (r_wdog == WD_LAST) begin
            r_tout     <= 1'b1;
            r_gnt_vld  <= 1'b0;
            r_rr_ptr   <= w_next_ptr;
            r_beat_cnt <= '0;
            r_wdog     <= '0;
            r_state    <= S_IDLE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    req_wrdy_o = '0;
    if (r_gnt_vld && stg_wrdy_i) req_wrdy_o[r_gnt_idx] = 1'b1;
  end

  assign stg_wval_o = r_gnt_vld & req_wval_i[r_gnt_idx];
  assign gnt_idx_o  = r_gnt_idx;
  assign gnt_vld_o  = r_gnt_vld;
  assign beat_cnt_o = r_beat_cnt;
  assign tout_o     = r_tout;

endmodule

// File: tb/tb_wbi_burst_sched.sv
// Directed bench for wbi_burst_sched: reads, locked writes, rotation, bl=0, watchdog, async reset.
module tb_wbi_burst_sched;

  localparam int NR  = 4;
  localparam int BL  = 10;
  localparam int TOW = 4;

  logic             mclk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_wval;
  logic [NR-1:0]    req_we;
  logic [NR*BL-1:0] req_bl;
  logic             stg_wrdy;
  logic             stg_wval;
  logic [NR-1:0]    req_wrdy;
  logic [1:0]       gnt_idx;
  logic             gnt_vld;
  logic [BL-1:0]    beat_cnt;
  logic             tout;

  int checks = 0;
  int errors = 0;

  wbi_burst_sched #(.NR(NR), .BL(BL), .TOW(TOW)) dut (
    .mclk       (mclk),
    .reset      (reset),
    .req_wval_i (req_wval),
    .req_we_i   (req_we),
    .req_bl_i   (req_bl),
    .stg_wrdy_i (stg_wrdy),
    .stg_wval_o (stg_wval),
    .req_wrdy_o (req_wrdy),
    .gnt_idx_o  (gnt_idx),
    .gnt_vld_o  (gnt_vld),
    .beat_cnt_o (beat_cnt),
    .tout_o     (tout)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and land 1 ns after it, clear of the edge.
  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_vld"},  32'(gnt_vld),  32'd0);
    check({tag, "_cnt"},  32'(beat_cnt), 32'd0);
    check({tag, "_sval"}, 32'(stg_wval), 32'd0);
    check({tag, "_wrdy"}, 32'(req_wrdy), 32'd0);
  endtask

  int exp_cnt;
  int waited;
  logic [3:0] rr_exp [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
  logic       wpat   [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    reset = 1'b1; req_wval = '0; req_we = '0; req_bl = '0; stg_wrdy = 1'b0;
    #12;
    check_idle("rst");
    check("rst_tout", 32'(tout), 32'd0);
    check("rst_idx", 32'(gnt_idx), 32'd0);
    reset = 1'b0;
    tick();

    // Single read from req0 with bl=8: one beat only.
    req_wval = 4'b0001; req_we = 4'b0000; req_bl[0*BL +: BL] = 10'd8; stg_wrdy = 1'b1;
    #1;
    check("rd_pre_vld", 32'(gnt_vld), 32'd0);
    tick();
    check("rd_vld", 32'(gnt_vld), 32'd1);
    check("rd_idx", 32'(gnt_idx), 32'd0);
    check("rd_cnt", 32'(beat_cnt), 32'd1);
    check("rd_sval", 32'(stg_wval), 32'd1);
    check("rd_wrdy", 32'(req_wrdy), 32'b0001);
    tick();
    req_wval = 4'b0000;
    #1;
    check_idle("rd_done");

    // Write burst of 4 from req2; req1 joins mid-burst and must wait.
    req_wval = 4'b0100; req_we = 4'b0100; req_bl[2*BL +: BL] = 10'd4;
    tick();
    check("wr_idx", 32'(gnt_idx), 32'd2);
    check("wr_cnt0", 32'(beat_cnt), 32'd4);
    req_wval = 4'b0110;
    exp_cnt = 4;
    for (int i = 0; i < 7; i++) begin
      stg_wrdy = wpat[i];
      #1;
      check("wr_cnt", 32'(beat_cnt), 32'(exp_cnt));
      check("wr_idx_hold", 32'(gnt_idx), 32'd2);
      check("wr_wrdy", 32'(req_wrdy), wpat[i] ? 32'b0100 : 32'b0000);
      if (wpat[i]) exp_cnt--;
      tick();
    end
    req_wval = 4'b0010;
    stg_wrdy = 1'b1;
    #1;
    check("wr_bubble_vld", 32'(gnt_vld), 32'd0);
    check("wr_bubble_cnt", 32'(beat_cnt), 32'd0);
    tick();
    check("wr_next_vld", 32'(gnt_vld), 32'd1);
    check("wr_next_idx", 32'(gnt_idx), 32'd1);
    tick();
    req_wval = 4'b0000;

    // bl=0 write from req3 is a single beat.
    req_wval = 4'b1000; req_we = 4'b1000; req_bl[3*BL +: BL] = 10'd0;
    tick();
    check("bl0_idx", 32'(gnt_idx), 32'd3);
    check("bl0_cnt", 32'(beat_cnt), 32'd1);
    tick();
    req_wval = 4'b0000;
    #1;
    check_idle("bl0_done");

    // All four requesters issue reads continuously: strict rotation from pointer 0.
    req_wval = 4'b1111; req_we = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rr_vld", 32'(gnt_vld), 32'd1);
      check("rr_idx", 32'(gnt_idx), 32'(rr_exp[i]));
      tick();
      check("rr_gap", 32'(gnt_vld), 32'd0);
    end
    req_wval = 4'b0000;

    // Watchdog: req1 write bl=3 stalls after one beat; req2 waits with a bl=5 write.
    req_wval = 4'b0110; req_we = 4'b0110;
    req_bl[1*BL +: BL] = 10'd3; req_bl[2*BL +: BL] = 10'd5;
    tick();
    check("wd_idx", 32'(gnt_idx), 32'd1);
    check("wd_cnt0", 32'(beat_cnt), 32'd3);
    tick();
    req_wval = 4'b0100;
    #1;
    check("wd_cnt1", 32'(beat_cnt), 32'd2);
    check("wd_sval", 32'(stg_wval), 32'd0);
    waited = 0;
    while (tout !== 1'b1 && waited < 40) begin
      tick();
      waited++;
      if (waited == 10) check("wd_hold_cnt", 32'(beat_cnt), 32'd2);
    end
    check("wd_delay", 32'(waited), 32'd15);
    check("wd_tout", 32'(tout), 32'd1);
    check("wd_rel_vld", 32'(gnt_vld), 32'd0);
    check("wd_rel_cnt", 32'(beat_cnt), 32'd0);
    stg_wrdy = 1'b0;
    tick();
    check("wd_pulse_end", 32'(tout), 32'd0);
    check("wd_next_idx", 32'(gnt_idx), 32'd2);
    check("wd_next_vld", 32'(gnt_vld), 32'd1);
    check("wd_next_cnt", 32'(beat_cnt), 32'd5);

    // Async reset mid-burst, away from any edge.
    reset = 1'b1;
    #1;
    check_idle("arst");
    check("arst_idx", 32'(gnt_idx), 32'd0);
    #1;
    reset = 1'b0;
    req_wval = 4'b1111; req_we = 4'b0000; stg_wrdy = 1'b1;
    tick();
    check("arst_restart_vld", 32'(gnt_vld), 32'd1);
    check("arst_restart_idx", 32'(gnt_idx), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
